dmem_port_arbiter: RTL and testbench

Sits in front of the single-port word-wide data memory and shares it between two requesters: port 0 (core load/store unit) and port 1 (debug/DMA loader). It accepts byte-addressed load/store requests of byte, halfword or word size. Sub-word stores use a read-modify-write sequence, because the memory only supports whole-word writes. Loads return a lane-extracted, sign- or zero-extended result. Requests are served one at a time under a round-robin policy.

---
 rtl/dmem_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Two-port round-robin front end for a single-port word memory.
// Sub-word stores are read-modify-write; loads are lane-extracted and sign/zero extended.
module dmem_port_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic                  p0_req_we,
  input  logic [1:0]            p0_req_size,
  input  logic                  p0_req_unsigned,
  input  logic [ADDR_WIDTH+1:0] p0_req_addr,
  input  logic [DATA_WIDTH-1:0] p0_req_wdata,
  output logic                  p0_rsp_valid,
  output logic [DATA_WIDTH-1:0] p0_rsp_rdata,
  output logic                  p0_rsp_err,
  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic                  p1_req_we,
  input  logic [1:0]            p1_req_size,
  input  logic                  p1_req_unsigned,
  input  logic [ADDR_WIDTH+1:0] p1_req_addr,
  input  logic [DATA_WIDTH-1:0] p1_req_wdata,
  output logic                  p1_rsp_valid,
  output logic [DATA_WIDTH-1:0] p1_rsp_rdata,
  output logic                  p1_rsp_err,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int AW        = ADDR_WIDTH + 2;

  typedef struct packed {
    logic                  we;
    logic [1:0]            size;
    logic                  uns;
    logic [AW-1:0]         addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t                state, state_nxt;
  req_t                  req_q, req_in;
  logic                  owner_q, last_grant, err_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic                  grant0, grant1, acc, bad_in;

  // Tie goes to whichever port was not served last.
  assign grant0 = (state == IDLE) && p0_req_valid && (!p1_req_valid || last_grant);
  assign grant1 = (state == IDLE) && p1_req_valid && (!p0_req_valid || !last_grant);
  assign acc    = grant0 || grant1;
  assign p0_req_ready = grant0;
  assign p1_req_ready = grant1;

  assign req_in = grant1 ?
    '{we: p1_req_we, size: p1_req_size, uns: p1_req_unsigned, addr: p1_req_addr, wdata: p1_req_wdata} :
    '{we: p0_req_we, size: p0_req_size, uns: p0_req_unsigned, addr: p0_req_addr, wdata: p0_req_wdata};

  always_comb begin
    bad_in = 1'b0;
    case (req_in.size)
      2'b01:   bad_in = req_in.addr[0];
      2'b10:   bad_in = |req_in.addr[1:0];
      2'b11:   bad_in = 1'b1;
      default: bad_in = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (acc) begin
        if (bad_in)                                 state_nxt = RESP;
        else if (!req_in.we || req_in.size != 2'b10) state_nxt = READ;
        else                                        state_nxt = WRITE;
      end
      READ:    state_nxt = req_q.we ? WRITE : RESP;
      WRITE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_q      <= '0;
      owner_q    <= 1'b0;
      last_grant <= 1'b1;
      err_q      <= 1'b0;
      word_q     <= '0;
    end else begin
      state <= state_nxt;
      if (acc) begin
        req_q      <= req_in;
        owner_q    <= grant1;
        last_grant <= grant1;
        err_q      <= bad_in;
      end
      if (state == READ) word_q <= mem_rdata;
    end
  end

  // Store merge: replicate store data across lanes, then pick per-lane by byte enable.
  logic [NUM_LANES-1:0]        be;
  logic [NUM_LANES-1:0][7:0]   rep, merged, wlanes;

  assign wlanes = word_q;

  always_comb begin
    be  = '1;
    rep = req_q.wdata;
    case (req_q.size)
      2'b00: begin
        be  = NUM_LANES'(1) << req_q.addr[1:0];
        rep = {NUM_LANES{req_q.wdata[7:0]}};
      end
      2'b01: begin
        be  = req_q.addr[1] ? NUM_LANES'(4'b1100) : NUM_LANES'(4'b0011);
        rep = {(NUM_LANES/2){req_q.wdata[15:0]}};
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign merged[i] = be[i] ? rep[i] : wlanes[i];
  end

  assign mem_we    = (state == WRITE);
  assign mem_addr  = (state == READ || state == WRITE) ? req_q.addr[AW-1:2] : '0;
  assign mem_wdata = (state == WRITE) ? merged : '0;

  logic [7:0]            ld_b;
  logic [15:0]           ld_h;
  logic [DATA_WIDTH-1:0] ld_data, rsp_data;

  assign ld_b = wlanes[req_q.addr[1:0]];
  assign ld_h = req_q.addr[1] ? word_q[31:16] : word_q[15:0];

  always_comb begin
    case (req_q.size)
      2'b00:   ld_data = {{(DATA_WIDTH-8){!req_q.uns && ld_b[7]}}, ld_b};
      2'b01:   ld_data = {{(DATA_WIDTH-16){!req_q.uns && ld_h[15]}}, ld_h};
      default: ld_data = word_q;
    endcase
  end

  assign rsp_data = (state == RESP && !req_q.we && !err_q) ? ld_data : '0;

  assign p0_rsp_valid = (state == RESP) && !owner_q;
  assign p1_rsp_valid = (state == RESP) && owner_q;
  assign p0_rsp_rdata = p0_rsp_valid ? rsp_data : '0;
  assign p1_rsp_rdata = p1_rsp_valid ? rsp_data : '0;
  assign p0_rsp_err   = p0_rsp_valid && err_q;
  assign p1_rsp_err   = p1_rsp_valid && err_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: drivers push expected responses, a monitor pops them.
module tb_dmem_port_arbiter;
  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p0_req_valid = 0, p0_req_we = 0, p0_req_unsigned = 0;
  logic [1:0]  p0_req_size = 0;
  logic [11:0] p0_req_addr = 0;
  logic [31:0] p0_req_wdata = 0;
  logic        p1_req_valid = 0, p1_req_we = 0, p1_req_unsigned = 0;
  logic [1:0]  p1_req_size = 0;
  logic [11:0] p1_req_addr = 0;
  logic [31:0] p1_req_wdata = 0;
  logic        p0_req_ready, p1_req_ready;
  logic        p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err;
  logic [31:0] p0_rsp_rdata, p1_rsp_rdata;
  logic        mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  dmem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_size(p0_req_size), .p0_req_unsigned(p0_req_unsigned), .p0_req_addr(p0_req_addr),
    .p0_req_wdata(p0_req_wdata), .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
    .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_size(p1_req_size), .p1_req_unsigned(p1_req_unsigned), .p1_req_addr(p1_req_addr),
    .p1_req_wdata(p1_req_wdata), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
    .p1_rsp_err(p1_rsp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [1024];
  int          wr_cnt = 0;
  int          cyc = 0;
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (mem_we) begin
      mem[mem_addr] = mem_wdata;
      wr_cnt = wr_cnt + 1;
    end
  end

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          t;
    int          lat;
  } exp_t;

  exp_t q0[$], q1[$];
  int   glog[$];
  int   checks = 0, errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: grant log, response checking against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (p0_req_ready && p0_req_valid) glog.push_back(0);
    if (p1_req_ready && p1_req_valid) glog.push_back(1);
    if (p0_rsp_valid && p1_rsp_valid) chk("rsp_both", 1, 0);
    if (p0_rsp_valid) begin
      if (q0.size() == 0) chk("p0_unexpected_rsp", 1, 0);
      else begin
        e = q0.pop_front();
        chk("p0_rdata", p0_rsp_rdata, e.rd);
        chk("p0_err", {31'd0, p0_rsp_err}, {31'd0, e.err});
        chk("p0_latency", cyc - e.t, e.lat);
      end
    end
    if (p1_rsp_valid) begin
      if (q1.size() == 0) chk("p1_unexpected_rsp", 1, 0);
      else begin
        e = q1.pop_front();
        chk("p1_rdata", p1_rsp_rdata, e.rd);
        chk("p1_err", {31'd0, p1_rsp_err}, {31'd0, e.err});
        chk("p1_latency", cyc - e.t, e.lat);
      end
    end
  end

  // Called just after a rising edge; returns just after the edge following accept.
  task automatic issue(int p, bit we, logic [1:0] size, bit uns, logic [11:0] addr,
                       logic [31:0] wdata, logic [31:0] exp_rd, bit exp_err, int lat, bit push);
    exp_t e;
    bit   done = 0;
    if (p == 0) begin
      p0_req_we = we; p0_req_size = size; p0_req_unsigned = uns;
      p0_req_addr = addr; p0_req_wdata = wdata; p0_req_valid = 1;
    end else begin
      p1_req_we = we; p1_req_size = size; p1_req_unsigned = uns;
      p1_req_addr = addr; p1_req_wdata = wdata; p1_req_valid = 1;
    end
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if ((p == 0) ? p0_req_ready : p1_req_ready) begin
        done = 1;
        e.rd = exp_rd; e.err = exp_err; e.t = cyc; e.lat = lat;
        if (push) begin
          if (p == 0) q0.push_back(e); else q1.push_back(e);
        end
      end
      @(posedge clk); #1;
    end
    if (p == 0) p0_req_valid = 0; else p1_req_valid = 0;
    if (!done) chk($sformatf("p%0d_accept_timeout", p), 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clk);
    #1;
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
  endtask

  task automatic chk_idle_outputs(string tag);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 0);
    chk({tag, "_mem_addr"}, {22'd0, mem_addr}, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_rsp_valid"}, {30'd0, p1_rsp_valid, p0_rsp_valid}, 0);
    chk({tag, "_rsp_err"}, {30'd0, p1_rsp_err, p0_rsp_err}, 0);
    chk({tag, "_rsp_rdata"}, p0_rsp_rdata | p1_rsp_rdata, 0);
  endtask

  initial begin
    int w0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    #12;
    chk_idle_outputs("reset");
    chk("reset_ready", {30'd0, p1_req_ready, p0_req_ready}, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // Word store then load back.
    issue(0, 1, 2'b10, 0, 12'h010, 32'hDEADBEEF, 32'h0, 0, 2, 1);
    drain();
    chk("sw_mem", mem[4], 32'hDEADBEEF);
    @(posedge clk); #1;
    issue(0, 0, 2'b10, 0, 12'h010, 32'h0, 32'hDEADBEEF, 0, 2, 1);
    drain();

    // Byte store read-modify-write from port 1.
    mem[4] = 32'h11223344;
    w0 = wr_cnt;
    @(posedge clk); #1;
    issue(1, 1, 2'b00, 0, 12'h012, 32'h000000AA, 32'h0, 0, 3, 1);
    drain();
    chk("sb_mem", mem[4], 32'h11AA3344);
    chk("sb_wr_cnt", wr_cnt - w0, 1);

    // Half store into the upper lane pair.
    @(posedge clk); #1;
    issue(0, 1, 2'b01, 0, 12'h012, 32'hCAFE5A5A, 32'h0, 0, 3, 1);
    drain();
    chk("sh_mem", mem[4], 32'h5A5A3344);

    // Load extraction and extension.
    mem[4] = 32'h80FF7F01;
    @(posedge clk); #1;
    issue(0, 0, 2'b00, 0, 12'h011, 0, 32'h0000007F, 0, 2, 1);
    issue(0, 0, 2'b00, 1, 12'h012, 0, 32'h000000FF, 0, 2, 1);
    issue(1, 0, 2'b01, 0, 12'h012, 0, 32'hFFFF80FF, 0, 2, 1);
    issue(0, 0, 2'b01, 1, 12'h012, 0, 32'h000080FF, 0, 2, 1);
    issue(0, 0, 2'b00, 0, 12'h013, 0, 32'hFFFFFF80, 0, 2, 1);
    drain();

    // Errors: misaligned word load, misaligned half store, reserved size.
    w0 = wr_cnt;
    @(posedge clk); #1;
    issue(0, 0, 2'b10, 0, 12'h013, 0, 32'h0, 1, 1, 1);
    issue(1, 1, 2'b01, 0, 12'h011, 32'hFFFF, 32'h0, 1, 1, 1);
    issue(0, 0, 2'b11, 0, 12'h010, 0, 32'h0, 1, 1, 1);
    drain();
    chk("err_no_write", wr_cnt - w0, 0);
    chk("err_mem_intact", mem[4], 32'h80FF7F01);

    // Round robin with both ports held valid; last grant was p0, so p1 goes first.
    mem[8] = 32'h0000A0A0;
    mem[9] = 32'hB1B1B1B1;
    glog.delete();
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 3; i++) issue(0, 0, 2'b10, 0, 12'h020, 0, 32'h0000A0A0, 0, 2, 1);
      end
      begin
        for (int i = 0; i < 3; i++) issue(1, 0, 2'b10, 0, 12'h024, 0, 32'hB1B1B1B1, 0, 2, 1);
      end
    join
    drain();
    chk("rr_grants", glog.size(), 6);
    for (int i = 0; i < 6 && i < glog.size(); i++)
      chk($sformatf("rr_grant%0d", i), glog[i], (i % 2 == 0) ? 1 : 0);

    // Reset during the READ cycle of a byte store.
    mem[4] = 32'h11223344;
    w0 = wr_cnt;
    @(posedge clk); #1;
    issue(1, 1, 2'b00, 0, 12'h012, 32'h000000AA, 32'h0, 0, 3, 0);
    rst_n = 0;
    #1;
    chk_idle_outputs("midrst");
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1;
    chk("midrst_mem", mem[4], 32'h11223344);
    chk("midrst_wr_cnt", wr_cnt - w0, 0);
    glog.delete();
    @(posedge clk); #1;
    fork
      issue(0, 0, 2'b10, 0, 12'h010, 0, 32'h11223344, 0, 2, 1);
      issue(1, 0, 2'b10, 0, 12'h024, 0, 32'hB1B1B1B1, 0, 2, 1);
    join
    drain();
    chk("post_rst_grants", glog.size(), 2);
    if (glog.size() >= 2) begin
      chk("post_rst_first", glog[0], 0);
      chk("post_rst_second", glog[1], 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1);
  end
endmodule
